// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: core dmem port, on-chip RAM port and peripheral bus seen by the bridge.
interface dmem_bridge_if #(parameter int RAM_ADDR_WIDTH = 14);
  logic [31:0] dmem_address;
  logic dmem_enable;
  logic dmem_write_enable;
  logic [2:0] dmem_write_mode;
  logic [31:0] dmem_write_data;
  logic dmem_read_enable;
  logic [2:0] dmem_read_mode;
  logic [31:0] dmem_read_data;
  logic dmem_wait;
  logic misaligned;
  logic bus_error;
  logic [RAM_ADDR_WIDTH-1:0] ram_address;
  logic ram_enable;
  logic [3:0] ram_byte_enable;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic per_req;
  logic per_write;
  logic [31:0] per_address;
  logic [3:0] per_byte_enable;
  logic [31:0] per_write_data;
  logic [31:0] per_read_data;
  logic per_ack;
  modport slave (
    input dmem_address, dmem_enable, dmem_write_enable, dmem_write_mode, dmem_write_data,
    input dmem_read_enable, dmem_read_mode, ram_read_data, per_read_data, per_ack,
    output dmem_read_data, dmem_wait, misaligned, bus_error,
    output ram_address, ram_enable, ram_byte_enable, ram_write_data,
    output per_req, per_write, per_address, per_byte_enable, per_write_data
  );
  modport master (
    output dmem_address, dmem_enable, dmem_write_enable, dmem_write_mode, dmem_write_data,
    output dmem_read_enable, dmem_read_mode, ram_read_data, per_read_data, per_ack,
    input dmem_read_data, dmem_wait, misaligned, bus_error,
    input ram_address, ram_enable, ram_byte_enable, ram_write_data,
    input per_req, per_write, per_address, per_byte_enable, per_write_data
  );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: decodes core data accesses into on-chip RAM or the stalling peripheral bus,
// steering store lanes and right-aligning load data.
module dmem_bridge #(
  parameter int RAM_ADDR_WIDTH = 14,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset_n,
  dmem_bridge_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {ZERO, RAM, HOLD} src_t;
  state_t state;
  src_t src;
  logic [CW-1:0] counter;
  logic [31:0] hold;
  logic [1:0] off;
  logic [31:0] a, d, wdata;
  logic wr, live, accept, illegal, mis, ok, mmio;
  logic [1:0] size;
  logic [3:0] mask;
  always_comb begin
    a = bus.dmem_address;
    d = bus.dmem_write_data;
    wr = bus.dmem_write_enable;
    live = bus.dmem_enable & (bus.dmem_read_enable | wr);
    accept = live & reset_n & (state != BUSY);
    size = wr ? bus.dmem_write_mode[1:0] : bus.dmem_read_mode[1:0];
    illegal = wr ? (bus.dmem_write_mode > 3'd2)
                 : ((bus.dmem_read_mode[1:0] == 2'b11) | (bus.dmem_read_mode[2:1] == 2'b11));
    mis = ((size == 2'd1) & a[0]) | ((size == 2'd2) & (a[1:0] != 2'd0));
    ok = accept & ~illegal & ~mis;
    mmio = a[31];
    mask = (size == 2'd0) ? 4'b0001 << a[1:0] : (size == 2'd1) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = (size == 2'd0) ? {4{d[7:0]}} : (size == 2'd1) ? {2{d[15:0]}} : d;
    bus.misaligned = accept & ~illegal & mis;
    bus.ram_enable = ok & ~mmio;
    bus.ram_byte_enable = (ok & ~mmio & wr) ? mask : 4'b0000;
    bus.ram_address = a[RAM_ADDR_WIDTH+1:2];
    bus.ram_write_data = wdata;
    bus.dmem_read_data = (state == BUSY) ? 32'd0
                       : (src == RAM) ? bus.ram_read_data >> {off, 3'b000}
                       : (src == HOLD) ? hold : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      src <= ZERO;
      counter <= '0;
      hold <= 32'd0;
      off <= 2'd0;
      bus.dmem_wait <= 1'b0;
      bus.bus_error <= 1'b0;
      bus.per_req <= 1'b0;
      bus.per_write <= 1'b0;
      bus.per_address <= 32'd0;
      bus.per_byte_enable <= 4'd0;
      bus.per_write_data <= 32'd0;
    end else begin
      bus.bus_error <= 1'b0;
      if (state == BUSY) begin
        counter <= counter + 1'b1;
        if (bus.per_ack || counter == CW'(TIMEOUT)) begin
          state <= RESP;
          src <= HOLD;
          bus.per_req <= 1'b0;
          bus.dmem_wait <= 1'b0;
          hold <= (bus.per_ack & ~bus.per_write) ? bus.per_read_data >> {off, 3'b000} : 32'd0;
          bus.bus_error <= ~bus.per_ack;
        end
      end else begin
        // the core always advances out of RESP, so the source is refreshed even without enable
        if (bus.dmem_enable || state == RESP) begin
          src <= (ok & ~mmio & ~wr) ? RAM : ZERO;
          off <= a[1:0];
        end
        if (ok & mmio) begin
          state <= BUSY;
          counter <= '0;
          bus.per_req <= 1'b1;
          bus.dmem_wait <= 1'b1;
          bus.per_write <= wr;
          bus.per_address <= a;
          bus.per_byte_enable <= mask;
          bus.per_write_data <= wdata;
        end else if (state == RESP) begin
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: random and directed accesses against a byte-addressed memory model,
// with a scoreboard monitor checking load data and bus errors in each response cycle.
module tb_dmem_bridge;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  dmem_bridge_if #(.RAM_ADDR_WIDTH(14)) bus ();
  dmem_bridge #(.RAM_ADDR_WIDTH(14), .TIMEOUT(TO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {int cyc; logic [31:0] data; logic berr;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] ref_mem [0:65535];
  logic [31:0] ram_words [0:16383];
  logic resp_en = 1'b1;
  int cur_delay = 0;
  int busy_cyc = 0;
  logic [31:0] cur_pdata, exp_paddr, exp_plane, exp_plm;
  logic [3:0] exp_pbe;
  logic exp_pwr;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // physical synchronous RAM driven purely by the ram_* port
  initial begin
    logic r_en;
    logic [13:0] r_a;
    logic [3:0] r_be;
    logic [31:0] r_wd;
    bus.ram_read_data = 32'd0;
    forever begin
      @(negedge clk);
      r_en = bus.ram_enable;
      r_a = bus.ram_address;
      r_be = bus.ram_byte_enable;
      r_wd = bus.ram_write_data;
      @(posedge clk);
      if (r_en) begin
        for (int k = 0; k < 4; k++) if (r_be[k]) ram_words[r_a][8*k +: 8] = r_wd[8*k +: 8];
        bus.ram_read_data = ram_words[r_a];
      end
    end
  end

  // peripheral: acks in the cur_delay-th cycle of per_req
  initial begin
    bus.per_ack = 1'b0;
    bus.per_read_data = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        bus.per_ack = 1'b0;
        if (bus.per_req) begin
          busy_cyc++;
          if (busy_cyc == 1) begin
            check("per_address", bus.per_address, exp_paddr);
            check("per_byte_enable", {28'd0, bus.per_byte_enable}, {28'd0, exp_pbe});
            check("per_write", {31'd0, bus.per_write}, {31'd0, exp_pwr});
            if (exp_pwr) check("per_write_data", bus.per_write_data & exp_plm, exp_plane);
          end
          if (busy_cyc == cur_delay) begin
            bus.per_ack = 1'b1;
            bus.per_read_data = cur_pdata;
          end
        end else busy_cyc = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && sb.size() > 0 && sb[0].cyc < cyc && !bus.dmem_wait) begin
        e = sb.pop_front();
        check("read_data", bus.dmem_read_data, e.data);
        check("bus_error", {31'd0, bus.bus_error}, {31'd0, e.berr});
      end
    end
  end

  task automatic issue(logic we, logic [2:0] wm, logic re, logic [2:0] rm, logic [31:0] a,
                       logic [31:0] d, int delay, logic [31:0] pd);
    int size, off, stall, n;
    logic legal, mis, ok, mmio, berr;
    logic [31:0] exp, lm, lane;
    logic [3:0] be;
    off = int'(a[1:0]);
    if (we) size = (wm == 0) ? 1 : (wm == 1) ? 2 : (wm == 2) ? 4 : 0;
    else size = (rm == 0 || rm == 4) ? 1 : (rm == 1 || rm == 5) ? 2 : (rm == 2) ? 4 : 0;
    legal = (we || re) && size != 0;
    mis = legal && (off % size != 0);
    ok = legal && !mis;
    mmio = a[31];
    be = 4'd0;
    lm = 32'd0;
    if (ok) for (int k = 0; k < size; k++) begin
      be[off + k] = 1'b1;
      lm[8*(off + k) +: 8] = 8'hFF;
    end
    lane = (size == 4) ? d : (d & ((32'd1 << (8 * size)) - 1)) << (8 * off);
    exp = 32'd0;
    berr = 1'b0;
    stall = 0;
    if (ok && !mmio) begin
      if (we) for (int k = 0; k < size; k++) ref_mem[int'(a[15:0]) + k] = d[8*k +: 8];
      else for (int k = 0; k < 4 - off; k++) exp[8*k +: 8] = ref_mem[int'(a[15:0]) + k];
    end else if (ok) begin
      berr = delay > TO + 1;
      stall = berr ? TO + 1 : delay;
      if (!we && !berr) exp = pd >> (8 * off);
      cur_delay = delay;
      cur_pdata = pd;
      exp_paddr = a;
      exp_pbe = be;
      exp_pwr = we;
      exp_plane = lane;
      exp_plm = lm;
    end
    bus.dmem_enable = 1'b1;
    bus.dmem_write_enable = we;
    bus.dmem_write_mode = wm;
    bus.dmem_read_enable = re;
    bus.dmem_read_mode = rm;
    bus.dmem_address = a;
    bus.dmem_write_data = d;
    sb.push_back('{cyc, exp, berr});
    #1;
    check("misaligned", {31'd0, bus.misaligned}, {31'd0, mis});
    check("ram_enable", {31'd0, bus.ram_enable}, {31'd0, ok && !mmio});
    if (ok && !mmio && we) begin
      check("ram_byte_enable", {28'd0, bus.ram_byte_enable}, {28'd0, be});
      check("ram_write_data", bus.ram_write_data & lm, lane);
    end
    @(posedge clk);
    #1;
    bus.dmem_enable = 1'b0;
    n = 0;
    while (bus.dmem_wait && n < 2 * TO + 10) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("stall_cycles", n, stall);
  endtask

  task automatic idle();
    bus.dmem_enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w, a;
    logic [2:0] wm, rm;
    logic we;
    int r;
    for (int i = 0; i < 16384; i++) begin
      w = $urandom;
      ram_words[i] = w;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
    end
    bus.dmem_enable = 1'b0;
    bus.dmem_write_enable = 1'b0;
    bus.dmem_read_enable = 1'b0;
    bus.dmem_write_mode = 3'd0;
    bus.dmem_read_mode = 3'd0;
    bus.dmem_address = 32'd0;
    bus.dmem_write_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dmem_wait", {31'd0, bus.dmem_wait}, 32'd0);
    check("rst_per_req", {31'd0, bus.per_req}, 32'd0);
    check("rst_bus_error", {31'd0, bus.bus_error}, 32'd0);
    check("rst_ram_enable", {31'd0, bus.ram_enable}, 32'd0);
    check("rst_read_data", bus.dmem_read_data, 32'd0);
    reset_n = 1'b1;
    issue(1, 3'd0, 0, 3'd0, 32'h103, 32'h000000AB, 0, 0);
    issue(0, 3'd0, 1, 3'd4, 32'h103, 32'd0, 0, 0);
    issue(1, 3'd2, 0, 3'd0, 32'h200, 32'h12345678, 0, 0);
    issue(0, 3'd0, 1, 3'd2, 32'h200, 32'd0, 0, 0);
    issue(0, 3'd0, 1, 3'd2, 32'h8000_0010, 32'd0, 3, 32'hDEADBEEF);
    idle();
    issue(0, 3'd0, 1, 3'd2, 32'h8000_0020, 32'd0, TO + 10, $urandom);
    issue(0, 3'd0, 1, 3'd2, 32'h202, 32'd0, 0, 0);
    issue(1, 3'd1, 0, 3'd0, 32'h101, $urandom, 0, 0);
    issue(1, 3'd2, 0, 3'd0, 32'h8000_0004, $urandom, 1, 0);
    issue(0, 3'd0, 1, 3'd2, 32'h40, 32'd0, 0, 0);
    idle();
    // reset during a stalled peripheral read, then a stray ack
    resp_en = 1'b0;
    idle();
    bus.dmem_enable = 1'b1;
    bus.dmem_write_enable = 1'b0;
    bus.dmem_read_enable = 1'b1;
    bus.dmem_read_mode = 3'd2;
    bus.dmem_address = 32'h8000_0030;
    @(posedge clk);
    #1;
    bus.dmem_enable = 1'b0;
    check("busy_wait", {31'd0, bus.dmem_wait}, 32'd1);
    check("busy_per_req", {31'd0, bus.per_req}, 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy_per_req", {31'd0, bus.per_req}, 32'd0);
    check("rst_busy_wait", {31'd0, bus.dmem_wait}, 32'd0);
    reset_n = 1'b1;
    bus.per_ack = 1'b1;
    bus.per_read_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.per_ack = 1'b0;
    check("late_ack_per_req", {31'd0, bus.per_req}, 32'd0);
    check("late_ack_wait", {31'd0, bus.dmem_wait}, 32'd0);
    check("late_ack_data", bus.dmem_read_data, 32'd0);
    resp_en = 1'b1;
    issue(0, 3'd0, 1, 3'd2, 32'h200, 32'd0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      wm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      rm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) == 1 && rm != 3'd2 ? 3'd4 : 3'd0);
      if (rm == 3'd6) rm = 3'd2;
      a = {1'b0, 15'($urandom), 8'h00, 8'($urandom)};
      we = 1'($urandom);
      if (r == 0) idle();
      else if (r < 6) issue(we, wm, !we, rm, a, $urandom, 0, 0);
      else if (r < 8) issue(we, wm, !we, rm, {1'b1, a[30:0]}, $urandom,
                            ($urandom_range(0, 7) == 0) ? TO + 3 : $urandom_range(1, 5), $urandom);
      else issue(we, wm, we, rm, a, $urandom, 0, 0);
    end
    repeat (3) idle();
    check("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
